// File: rtl/vga_dither_pkg.sv
// Shared constants for the RGB565 -> RGB222 dithering output stage:
// Bayer 4x4 matrix, plain-rounding thresholds and pipeline latency.
package vga_dither_pkg;

  localparam int DITHER_LATENCY = 2;

  localparam logic [4:0] ROUND_5 = 5'd16;
  localparam logic [5:0] ROUND_6 = 6'd32;

  localparam logic [3:0] BAYER_4X4 [0:3][0:3] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  function automatic logic [3:0] bayer_lookup(input logic [1:0] row, input logic [1:0] col);
    return BAYER_4X4[row][col];
  endfunction

endpackage

// File: rtl/vga_dither_channel.sv
// One colour channel: stage 1 registers c*3 and its threshold, stage 2
// registers (c*3 + threshold) >> W_IN, blanked outside active video.
module vga_dither_channel
  import vga_dither_pkg::*;
#(
  parameter int W_IN = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            dither_en,
  input  logic            display_on,
  input  logic [3:0]      bayer_t,
  input  logic [W_IN-1:0] c,
  output logic [1:0]      c_out
);

  localparam int W_SUM = W_IN + 2;

  logic [W_SUM-1:0] triple_s;
  logic [W_SUM-1:0] triple_r;
  logic [W_SUM-1:0] sum_s;
  logic [W_IN-1:0]  dith_thresh_s;
  logic [W_IN-1:0]  round_s;
  logic [W_IN-1:0]  thresh_s;
  logic [W_IN-1:0]  thresh_r;
  logic             on_r;

  // Green scales the Bayer entry to 4t+2, the 5-bit channels to 2t+1.
  generate
    if (W_IN == 6) begin : g_w6
      assign dith_thresh_s = {bayer_t, 2'b10};
      assign round_s       = ROUND_6;
    end else begin : g_w5
      assign dith_thresh_s = {bayer_t, 1'b1};
      assign round_s       = ROUND_5;
    end
  endgenerate

  // Stage-1 operands: c*3 and the selected threshold.
  always_comb begin
    triple_s = {2'b00, c} + {1'b0, c, 1'b0};
    thresh_s = dither_en ? dith_thresh_s : round_s;
    sum_s    = triple_r + {2'b00, thresh_r};
  end

  // Stage 1 register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      triple_r <= '0;
      thresh_r <= '0;
      on_r     <= 1'b0;
    end else begin
      triple_r <= triple_s;
      thresh_r <= thresh_s;
      on_r     <= display_on;
    end
  end

  // Stage 2 register: top two bits of the sum never exceed 3.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_out <= 2'b00;
    end else if (on_r) begin
      c_out <= sum_s[W_SUM-1:W_IN];
    end else begin
      c_out <= 2'b00;
    end
  end

endmodule

// File: rtl/vga_rgb222_dither.sv
// RGB565 -> RGB222 VGA output stage with ordered (optionally temporal) Bayer
// dithering; syncs are delayed to stay aligned with the colour pipeline.
module vga_rgb222_dither
  import vga_dither_pkg::*;
#(
  parameter logic SYNC_ACTIVE_LEVEL = 1'b0,
  parameter int   W_POS             = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dither_en,
  input  logic             temporal_en,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             display_on,
  input  logic [W_POS-1:0] hpos,
  input  logic [W_POS-1:0] vpos,
  input  logic [4:0]       red,
  input  logic [5:0]       green,
  input  logic [4:0]       blue,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic [1:0]       vga_red,
  output logic [1:0]       vga_green,
  output logic [1:0]       vga_blue
);

  logic [DITHER_LATENCY-1:0] hsync_pipe_r;
  logic [DITHER_LATENCY-1:0] vsync_pipe_r;
  logic                      vsync_prev_r;
  logic [1:0]                frame_cnt_r;
  logic [1:0]                frame_eff_s;
  logic                      vsync_edge_s;
  logic [1:0]                row_s;
  logic [1:0]                col_s;
  logic [3:0]                bayer_t_s;
  logic                      pos_unused_s;

  assign pos_unused_s = ^{hpos[W_POS-1:2], vpos[W_POS-1:2]};

  // Bayer index: the pattern shifts diagonally with the frame count.
  always_comb begin
    vsync_edge_s = (vsync_in == SYNC_ACTIVE_LEVEL) && (vsync_prev_r != SYNC_ACTIVE_LEVEL);
    frame_eff_s  = temporal_en ? frame_cnt_r : 2'd0;
    row_s        = vpos[1:0] + frame_eff_s;
    col_s        = hpos[1:0] + {frame_eff_s[0], frame_eff_s[1]};
    bayer_t_s    = bayer_lookup(row_s, col_s);
  end

  // Frame counter advances on the leading edge of vsync.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vsync_prev_r <= ~SYNC_ACTIVE_LEVEL;
      frame_cnt_r  <= 2'd0;
    end else begin
      vsync_prev_r <= vsync_in;
      if (!temporal_en) begin
        frame_cnt_r <= 2'd0;
      end else if (vsync_edge_s) begin
        frame_cnt_r <= frame_cnt_r + 2'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  // Sync delay lines, same depth as the colour pipeline.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hsync_pipe_r <= {DITHER_LATENCY{~SYNC_ACTIVE_LEVEL}};
      vsync_pipe_r <= {DITHER_LATENCY{~SYNC_ACTIVE_LEVEL}};
    end else begin
      hsync_pipe_r <= {hsync_pipe_r[DITHER_LATENCY-2:0], hsync_in};
      vsync_pipe_r <= {vsync_pipe_r[DITHER_LATENCY-2:0], vsync_in};
    end
  end

  assign vga_hsync = hsync_pipe_r[DITHER_LATENCY-1];
  assign vga_vsync = vsync_pipe_r[DITHER_LATENCY-1];

  vga_dither_channel #(.W_IN(5)) u_red (
    .clock(clock), .reset(reset), .dither_en(dither_en), .display_on(display_on),
    .bayer_t(bayer_t_s), .c(red), .c_out(vga_red)
  );

  vga_dither_channel #(.W_IN(6)) u_green (
    .clock(clock), .reset(reset), .dither_en(dither_en), .display_on(display_on),
    .bayer_t(bayer_t_s), .c(green), .c_out(vga_green)
  );

  vga_dither_channel #(.W_IN(5)) u_blue (
    .clock(clock), .reset(reset), .dither_en(dither_en), .display_on(display_on),
    .bayer_t(bayer_t_s), .c(blue), .c_out(vga_blue)
  );

endmodule

// File: tb/tb_vga_rgb222_dither.sv
// Scoreboard bench for vga_rgb222_dither: stimulus pushes expected outputs
// tagged with their due cycle, a monitor pops and compares them.
module tb_vga_rgb222_dither;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dither_en = 1'b0;
  logic       temporal_en = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       display_on = 1'b0;
  logic [9:0] hpos = 10'd0;
  logic [9:0] vpos = 10'd0;
  logic [4:0] red = 5'd0;
  logic [5:0] green = 6'd0;
  logic [4:0] blue = 5'd0;
  logic       vga_hsync;
  logic       vga_vsync;
  logic [1:0] vga_red;
  logic [1:0] vga_green;
  logic [1:0] vga_blue;

  vga_rgb222_dither dut (
    .clock(clock), .reset(reset), .dither_en(dither_en), .temporal_en(temporal_en),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .display_on(display_on),
    .hpos(hpos), .vpos(vpos), .red(red), .green(green), .blue(blue),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         due;
    logic       hs;
    logic       vs;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   bt [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int model(input int c, input int w, input int t, input bit d);
    int thr;
    if (w == 5) thr = d ? (2 * t + 1) : 16;
    else        thr = d ? (4 * t + 2) : 32;
    return (3 * c + thr) >> w;
  endfunction

  // Monitor: reset-state checks while reset is high, scoreboard otherwise.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock or posedge reset);
      if (reset) begin
        sb.delete();
        #1;
        n_chk++;
        if (vga_hsync !== 1'b1 || vga_vsync !== 1'b1 || vga_red !== 2'd0 ||
            vga_green !== 2'd0 || vga_blue !== 2'd0) begin
          n_fail++;
          $display("FAIL reset_state t=%0t: got hs=%b vs=%b rgb=%0d/%0d/%0d, expected hs=1 vs=1 rgb=0/0/0",
                   $time, vga_hsync, vga_vsync, vga_red, vga_green, vga_blue);
        end
      end else begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          n_chk++;
          if (e.due != cyc || vga_hsync !== e.hs || vga_vsync !== e.vs ||
              vga_red !== e.r || vga_green !== e.g || vga_blue !== e.b) begin
            n_fail++;
            $display("FAIL %s due=%0d cyc=%0d: got hs=%b vs=%b rgb=%0d/%0d/%0d, expected hs=%b vs=%b rgb=%0d/%0d/%0d",
                     e.nm, e.due, cyc, vga_hsync, vga_vsync, vga_red, vga_green, vga_blue,
                     e.hs, e.vs, e.r, e.g, e.b);
          end
        end
      end
    end
  end

  task automatic push_exp(input string nm, input int lat, input logic hs, input logic vs,
                          input int er, input int eg, input int eb);
    exp_t e;
    e.due = cyc + lat;
    e.hs  = hs;
    e.vs  = vs;
    e.r   = er[1:0];
    e.g   = eg[1:0];
    e.b   = eb[1:0];
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic drive(input string nm, input logic hs, input logic vs, input logic on,
                       input int h, input int v, input int r, input int g, input int b,
                       input int er, input int eg, input int eb);
    hsync_in   = hs;
    vsync_in   = vs;
    display_on = on;
    hpos       = h[9:0];
    vpos       = v[9:0];
    red        = r[4:0];
    green      = g[5:0];
    blue       = b[4:0];
    push_exp(nm, 2, hs, vs, er, eg, eb);
    @(posedge clock);
    #1;
  endtask

  task automatic blank();
    hsync_in   = 1'b1;
    vsync_in   = 1'b1;
    display_on = 1'b0;
    red        = 5'd0;
    green      = 6'd0;
    blue       = 5'd0;
  endtask

  initial begin : timeout
    #1000000;
    $display("FAIL timeout: simulation did not reach the end of test");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int row;
    int col;
    int t;
    int ex2 [8] = '{0, 1, 1, 1, 0, 1, 1, 1};
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock);
    #1;

    // Plain rounding with an hsync pulse travelling alongside.
    dither_en = 1'b0;
    temporal_en = 1'b0;
    drive("round_a", 1'b1, 1'b1, 1'b1, 0, 0, 16, 32, 31, 2, 2, 3);
    drive("round_hs", 1'b0, 1'b1, 1'b1, 1, 0, 16, 32, 31, 2, 2, 3);
    drive("round_b", 1'b1, 1'b1, 1'b1, 2, 0, 16, 32, 31, 2, 2, 3);

    // Spatial dither along row 0, red=10, pattern period 4.
    dither_en = 1'b1;
    for (int h = 0; h < 8; h++)
      drive("bayer_row0", 1'b1, 1'b1, 1'b1, h, 0, 10, 0, 0, ex2[h], 0, 0);

    // Blanking forces black, syncs still delayed.
    drive("blank_a", 1'b0, 1'b1, 1'b0, 0, 0, 31, 63, 31, 0, 0, 0);
    drive("blank_b", 1'b1, 1'b0, 1'b0, 1, 0, 31, 63, 31, 0, 0, 0);
    drive("blank_c", 1'b0, 1'b0, 1'b0, 2, 0, 31, 63, 31, 0, 0, 0);
    drive("blank_d", 1'b1, 1'b1, 1'b0, 3, 0, 31, 63, 31, 0, 0, 0);

    // Sweep both modes, all 16 Bayer cells, every red/green value.
    for (int d = 0; d < 2; d++) begin
      dither_en = d[0];
      for (int idx = 0; idx < 16; idx++) begin
        row = idx / 4;
        col = idx % 4;
        t = bt[idx];
        for (int i = 0; i < 64; i++)
          drive("sweep", 1'b1, 1'b1, 1'b1, col + 1020, row + 4 * i, i % 32, i, 31 - (i % 32),
                model(i % 32, 5, t, d[0]), model(i, 6, t, d[0]), model(31 - (i % 32), 5, t, d[0]));
      end
    end

    // Temporal: one vsync edge moves pixel (0,0) to t=14.
    dither_en = 1'b1;
    temporal_en = 1'b1;
    drive("pre_edge", 1'b1, 1'b1, 1'b1, 0, 0, 10, 0, 0, 0, 0, 0);
    drive("vs_edge1", 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("frame1_px", 1'b1, 1'b1, 1'b1, 0, 0, 10, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive("vs_edge", 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive("vs_idle", 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    drive("frame_wrap_px", 1'b1, 1'b1, 1'b1, 0, 0, 10, 0, 0, 0, 0, 0);

    // Advance to frame 1, then reset mid-line with bright pixels in flight.
    drive("vs_edge_pre_rst", 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    dither_en = 1'b0;
    drive("bright_a", 1'b0, 1'b1, 1'b1, 1, 0, 31, 63, 31, 3, 3, 3);
    drive("bright_b", 1'b0, 1'b1, 1'b1, 2, 0, 31, 63, 31, 3, 3, 3);
    drive("bright_c", 1'b0, 1'b1, 1'b1, 3, 0, 31, 63, 31, 3, 3, 3);
    #2;
    blank();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock);
    #1;

    // First post-reset pixel appears exactly two clocks later; frame count is 0.
    push_exp("post_rst_idle", 1, 1'b1, 1'b1, 0, 0, 0);
    drive("post_rst_first", 1'b0, 1'b1, 1'b1, 0, 0, 31, 63, 31, 3, 3, 3);
    dither_en = 1'b1;
    drive("post_rst_frame0", 1'b1, 1'b1, 1'b1, 0, 0, 10, 0, 0, 0, 0, 0);
    blank();
    repeat (4) @(posedge clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
